// File: rtl/board_drawer_pkg.sv
// board_drawer shared types and constants
// FSM encodings, board geometry and palette values
package board_drawer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DRAW   = 2'b01,
    S_FINISH = 2'b10
  } state_t;

  localparam int GRID_DIM = 4;
  localparam int TILES    = GRID_DIM * GRID_DIM;
  localparam int VAL_W    = 4;
  localparam int BOARD_W  = TILES * VAL_W;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;

  localparam logic [COL_W-1:0] PAL_BLACK = 3'b000;
  localparam logic [COL_W-1:0] PAL_WHITE = 3'b111;
  localparam logic [COL_W-1:0] PAL_BORDER = PAL_WHITE;

endpackage

// File: rtl/board_drawer_if.sv
// board_drawer request and pixel-write bundle
// master = controller/adapter side, slave = drawer
interface board_drawer_if;
  import board_drawer_pkg::*;

  logic               start;
  logic [BOARD_W-1:0] values;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COL_W-1:0]   colour;
  logic               plot;
  logic               busy;
  logic               done;

  modport master (
    output start, values,
    input  x, y, colour, plot, busy, done
  );

  modport slave (
    input  start, values,
    output x, y, colour, plot, busy, done
  );

endinterface

// File: rtl/board_drawer_tile_palette.sv
// tile_palette: tile value + border flag to colour
// nonzero values cycle through colours 1..7
module tile_palette
  import board_drawer_pkg::*;
#(
  parameter logic [COL_W-1:0] BORDER_COLOUR = PAL_BORDER
) (
  input  logic [VAL_W-1:0] value_i,
  input  logic             border_i,
  output logic [COL_W-1:0] colour_o
);

  logic [VAL_W-1:0] vm1;
  logic [VAL_W-1:0] red;

  // fold (v-1) into 0..6, then shift to 1..7
  always_comb begin
    vm1 = value_i - 4'd1;
    red = vm1;
    if (vm1 >= 4'd14)
      red = vm1 - 4'd14;
    else if (vm1 >= 4'd7)
      red = vm1 - 4'd7;
    if (border_i)
      colour_o = BORDER_COLOUR;
    else if (value_i == '0)
      colour_o = PAL_BLACK;
    else
      colour_o = red[COL_W-1:0] + 3'd1;
  end

endmodule

// File: rtl/board_drawer.sv
// board_drawer: rasterises the 4x4 board, one pixel per clock
// snapshot taken at start, held for the whole redraw
module board_drawer
  import board_drawer_pkg::*;
#(
  parameter int               TILE_SIZE     = 16,
  parameter int               ORIGIN_X      = 48,
  parameter int               ORIGIN_Y      = 28,
  parameter logic [COL_W-1:0] BORDER_COLOUR = 3'b111
) (
  input  logic         clock,
  input  logic         reset,
  board_drawer_if.slave bus
);

  localparam int TW = $clog2(TILE_SIZE);
  localparam logic [TW-1:0] P_LAST = TW'(TILE_SIZE - 1);

  state_t             state_q;
  logic [BOARD_W-1:0] snap_q;
  logic [3:0]         tile_q;
  logic [TW-1:0]      px_q;
  logic [TW-1:0]      py_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [COL_W-1:0]   colour_q;
  logic               plot_q;
  logic               busy_q;
  logic               done_q;

  logic [1:0]         col;
  logic [1:0]         row;
  logic [X_W-1:0]     x_d;
  logic [Y_W-1:0]     y_d;
  logic [VAL_W-1:0]   val_d;
  logic               border_d;
  logic [COL_W-1:0]   colour_d;
  logic               px_end;
  logic               py_end;
  logic               tile_end;

  assign col      = tile_q[1:0];
  assign row      = tile_q[3:2];
  assign x_d      = X_W'(ORIGIN_X)
                  + X_W'(col * TILE_SIZE)
                  + X_W'(px_q);
  assign y_d      = Y_W'(ORIGIN_Y)
                  + Y_W'(row * TILE_SIZE)
                  + Y_W'(py_q);
  assign val_d    = snap_q[{~tile_q, 2'b00} +: VAL_W];
  assign border_d = (px_q == '0) || (py_q == '0);
  assign px_end   = (px_q == P_LAST);
  assign py_end   = (py_q == P_LAST);
  assign tile_end = (tile_q == 4'd15);

  tile_palette #(
    .BORDER_COLOUR(BORDER_COLOUR)
  ) u_pal (
    .value_i (val_d),
    .border_i(border_d),
    .colour_o(colour_d)
  );

  // redraw FSM with counters, snapshot and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      snap_q   <= '0;
      tile_q   <= '0;
      px_q     <= '0;
      py_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          plot_q <= 1'b0;
          done_q <= 1'b0;
          if (bus.start) begin
            snap_q  <= bus.values;
            tile_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_DRAW;
          end
        end
        S_DRAW: begin
          x_q      <= x_d;
          y_q      <= y_d;
          colour_q <= colour_d;
          plot_q   <= 1'b1;
          px_q     <= px_q + TW'(1);
          if (px_end) begin
            py_q <= py_q + TW'(1);
            if (py_end)
              tile_q <= tile_q + 4'd1;
          end
          if (px_end && py_end && tile_end)
            state_q <= S_FINISH;
        end
        S_FINISH: begin
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          plot_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_board_drawer.sv
// tb_board_drawer: directed tests for board_drawer
// frame capture monitor plus pixel table checks
module tb_board_drawer;

  localparam int N = 4096;

  typedef struct {
    int         b;
    int         x;
    int         y;
    logic [2:0] c;
  } pv_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_drawer_if bus();

  board_drawer dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int frame = 0;

  int cyc = 0;
  int mon_frame = 0;
  int plots = 0;
  int dones = 0;
  int done_cyc = 0;
  int overlap = 0;
  int bad = 0;
  int first_x = -1;
  int first_y = -1;
  int last_x = -1;
  int last_y = -1;
  logic [2:0] fb [0:255][0:127];
  int fbf [0:255][0:127];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (frame != mon_frame) begin
      mon_frame = frame;
      plots = 0;
      dones = 0;
      done_cyc = 0;
      overlap = 0;
      bad = 0;
      first_x = -1;
      first_y = -1;
    end
    if (bus.plot) begin
      if (plots == 0) begin
        first_x = int'(bus.x);
        first_y = int'(bus.y);
      end
      last_x = int'(bus.x);
      last_y = int'(bus.y);
      fb[bus.x][bus.y] = bus.colour;
      fbf[bus.x][bus.y] = frame;
      plots++;
    end
    if (bus.done) begin
      dones++;
      done_cyc = cyc;
    end
    if (bus.plot && bus.done) overlap++;
    if (bus.plot && !bus.busy) bad++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pix(input int x, input int y, input logic [2:0] c);
    int act;
    act = (fbf[x][y] == frame) ? int'(fb[x][y]) : -1;
    chk($sformatf("pix(%0d,%0d)", x, y), act, int'(c));
  endtask

  task automatic run_frame(input logic [63:0] v, input logic [63:0] v2,
                           input int mode, output int c0);
    int t;
    frame++;
    bus.values = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c0 = cyc;
    chk("busy_after_start", int'(bus.busy), 1);
    chk("plot_after_start", int'(bus.plot), 0);
    t = 0;
    while (t < 5000) begin
      @(negedge clk);
      t++;
      bus.start = 1'b0;
      if (dones != 0) break;
      if (mode == 1 && plots == 500) bus.values = v2;
      if (mode == 2 && (plots == 10 || plots == 4095 || plots == 4096))
        bus.start = 1'b1;
    end
    chk("frame_timeout", (t >= 5000) ? 1 : 0, 0);
    chk("plot_count", plots, N);
    chk("done_count", dones, 1);
    chk("done_latency", done_cyc - c0, N + 1);
    chk("done_plot_overlap", overlap, 0);
    chk("plot_not_busy", bad, 0);
    chk("end_done", int'(bus.done), 1);
    chk("end_busy", int'(bus.busy), 0);
    chk("end_plot", int'(bus.plot), 0);
  endtask

  logic [63:0] brd [3];
  pv_t tbl [17];

  initial begin
    int c0;
    int c1;
    int t;

    brd[0] = 64'h0;
    brd[1] = 64'hB000_0000_0000_0007;
    brd[2] = 64'h0123_4567_89AB_CDEF;

    tbl[0]  = '{0, 48, 28, 3'b111};
    tbl[1]  = '{0, 49, 29, 3'b000};
    tbl[2]  = '{0, 111, 91, 3'b000};
    tbl[3]  = '{0, 64, 28, 3'b111};
    tbl[4]  = '{1, 50, 30, 3'b100};
    tbl[5]  = '{1, 100, 80, 3'b111};
    tbl[6]  = '{1, 64, 28, 3'b111};
    tbl[7]  = '{1, 60, 40, 3'b100};
    tbl[8]  = '{1, 70, 46, 3'b000};
    tbl[9]  = '{2, 53, 65, 3'b001};
    tbl[10] = '{2, 101, 81, 3'b001};
    tbl[11] = '{2, 85, 81, 3'b111};
    tbl[12] = '{2, 85, 49, 3'b110};
    tbl[13] = '{2, 53, 33, 3'b000};
    tbl[14] = '{2, 69, 65, 3'b010};
    tbl[15] = '{2, 48, 70, 3'b111};
    tbl[16] = '{2, 53, 81, 3'b101};

    bus.start = 1'b1;
    bus.values = 64'hFFFF_FFFF_FFFF_FFFF;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_xy", int'(bus.x) + int'(bus.y), 0);
      chk("rst_colour", int'(bus.colour), 0);
      chk("rst_flags", int'({bus.plot, bus.busy, bus.done}), 0);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_plot", int'(bus.plot), 0);

    for (int b = 0; b < 3; b++) begin
      run_frame(brd[b], 64'h0, 0, c0);
      for (int i = 0; i < 17; i++)
        if (tbl[i].b == b)
          chk_pix(tbl[i].x, tbl[i].y, tbl[i].c);
      if (b == 0) begin
        chk("first_x", first_x, 48);
        chk("first_y", first_y, 28);
        chk("last_x", last_x, 111);
        chk("last_y", last_y, 91);
      end
    end

    run_frame(64'h0000_0100_0000_0000, 64'h0000_0200_0000_0000, 1, c0);
    chk_pix(70, 46, 3'b001);
    chk_pix(79, 59, 3'b001);
    chk_pix(64, 46, 3'b111);

    run_frame(brd[1], 64'h0, 2, c0);
    run_frame(brd[2], 64'h0, 0, c1);
    chk("restart_spacing", c1 - c0, N + 2);
    chk_pix(69, 65, 3'b010);

    frame++;
    bus.values = brd[1];
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (plots != 2000 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_2000", plots, 2000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_plot", int'(bus.plot), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    repeat (10) @(negedge clk);
    chk("midrst_plots", plots, 2000);
    chk("midrst_dones", dones, 0);

    run_frame(brd[0], 64'h0, 0, c0);
    chk("post_rst_first_x", first_x, 48);
    chk("post_rst_first_y", first_y, 28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
